// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and constants for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_wait_timer.sv
// rtl/hazard_wait_timer.sv - 8-bit data-memory wait counter with timeout comparator
module hazard_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (clear) begin
      r_cnt <= 8'd0;
    end else if (enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = (r_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline load/hold/flush sequencing for the 5-stage core
// Optional perf counters (stall_cnt, flush_cnt) under HAZARD_PERF_CNT_EN.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_access,
  input  logic       mem_branch_taken,
  input  logic       dm_ack,
  output logic       pc_we,
  output logic       ir1_we,
  output logic       ir2_we,
  output logic       ir3_we,
  output logic       ir1_flush,
  output logic       ir2_flush,
  output logic       ir3_flush,
  output logic       ir4_flush,
  output logic       dm_req,
  output logic       mem_timeout_err,
  output logic [1:0] hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  hz_state_t r_state;
  hz_state_t w_next_state;
  logic      r_err;
  logic      w_load_use;
  logic      w_ack;
  logic      w_expired;
  logic      w_timeout;
  logic      w_stall;
  logic      w_branch_flush;

  hazard_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state == HZ_RUN),
    .enable  (r_state == HZ_MEM_WAIT),
    .expired (w_expired)
  );

  assign w_load_use = ex_memread && (ex_rd != REG_X0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // An ack only counts while a request is outstanding.
  assign w_ack      = mem_access && dm_ack;
  assign w_timeout  = (r_state == HZ_MEM_WAIT) && !w_ack && w_expired;
  assign w_stall    = (r_state == HZ_RUN) ? (mem_access && !dm_ack)
                                          : (!w_ack && !w_timeout);
  assign w_branch_flush = !w_stall && mem_branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HZ_RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    pc_we        = 1'b1;
    ir1_we       = 1'b1;
    ir2_we       = 1'b1;
    ir3_we       = 1'b1;
    ir1_flush    = 1'b0;
    ir2_flush    = 1'b0;
    ir3_flush    = 1'b0;
    ir4_flush    = 1'b0;
    dm_req       = mem_access;

    case (r_state)
      HZ_RUN:      if (w_stall) w_next_state = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (w_ack || w_timeout) w_next_state = HZ_RUN;
      default:     w_next_state = HZ_RUN;
    endcase

    if (reset) begin
      pc_we     = 1'b0;
      ir1_we    = 1'b0;
      ir2_we    = 1'b0;
      ir3_we    = 1'b0;
      ir1_flush = 1'b1;
      ir2_flush = 1'b1;
      ir3_flush = 1'b1;
      ir4_flush = 1'b1;
      dm_req    = 1'b0;
    end else if (w_stall) begin
      pc_we     = 1'b0;
      ir1_we    = 1'b0;
      ir2_we    = 1'b0;
      ir3_we    = 1'b0;
      ir4_flush = 1'b1;
    end else begin
      if (mem_branch_taken) begin
        ir1_flush = 1'b1;
        ir2_flush = 1'b1;
        ir3_flush = 1'b1;
      end else if (w_load_use) begin
        pc_we     = 1'b0;
        ir1_we    = 1'b0;
        ir2_flush = 1'b1;
      end
      // Abandoned access: the pipeline moves on but its result never reaches WB.
      if (w_timeout) begin
        ir4_flush = 1'b1;
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign hz_state        = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!pc_we && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_branch_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused_branch_flush;
  assign w_unused_branch_flush = w_branch_flush;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       mem_access;
  logic       mem_branch_taken;
  logic       dm_ack;
  logic       pc_we, ir1_we, ir2_we, ir3_we;
  logic       ir1_flush, ir2_flush, ir3_flush, ir4_flush;
  logic       dm_req;
  logic       mem_timeout_err;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_we, ir1_we, ir2_we, ir3_we, ir1_flush, ir2_flush, ir3_flush, ir4_flush, dm_req}
  logic [8:0] ctl;
  assign ctl = {pc_we, ir1_we, ir2_we, ir3_we, ir1_flush, ir2_flush, ir3_flush, ir4_flush, dm_req};

  localparam logic [8:0] C_RESET    = 9'b0000_1111_0;
  localparam logic [8:0] C_NORMAL   = 9'b1111_0000_0;
  localparam logic [8:0] C_LOADUSE  = 9'b0011_0100_0;
  localparam logic [8:0] C_BRANCH   = 9'b1111_1110_0;
  localparam logic [8:0] C_MSTALL   = 9'b0000_0001_1;
  localparam logic [8:0] C_MADVANCE = 9'b1111_0000_1;
  localparam logic [8:0] C_TIMEOUT  = 9'b1111_0001_1;

  always #5 clk = ~clk;

  hazard_controller #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .ex_memread       (ex_memread),
    .ex_rd            (ex_rd),
    .mem_access       (mem_access),
    .mem_branch_taken (mem_branch_taken),
    .dm_ack           (dm_ack),
    .pc_we            (pc_we),
    .ir1_we           (ir1_we),
    .ir2_we           (ir2_we),
    .ir3_we           (ir3_we),
    .ir1_flush        (ir1_flush),
    .ir2_flush        (ir2_flush),
    .ir3_flush        (ir3_flush),
    .ir4_flush        (ir4_flush),
    .dm_req           (dm_req),
    .mem_timeout_err  (mem_timeout_err),
    .hz_state         (hz_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    ex_memread = 1'b0;
    ex_rd = 5'd0;
    mem_access = 1'b0;
    mem_branch_taken = 1'b0;
    dm_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    mem_access = 1'b1;
    #2;
    checks++;
    if (ctl !== C_RESET) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", ctl, C_RESET);
    end
    checks++;
    if (hz_state !== 2'd0 || mem_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d err=%b exp st=0 err=0", hz_state, mem_timeout_err);
    end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL idle_ctl got %b exp %b", ctl, C_NORMAL);
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_LOADUSE) begin
      errors++;
      $display("FAIL load_use_rs2 got %b exp %b", ctl, C_LOADUSE);
    end
    next_cycle();
    ex_memread = 1'b0; ex_rd = 5'd0;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL load_use_after got %b exp %b", ctl, C_NORMAL);
    end
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd1;
    #1;
    checks++;
    if (ctl !== C_LOADUSE) begin
      errors++;
      $display("FAIL load_use_rs1 got %b exp %b", ctl, C_LOADUSE);
    end
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd6; id_rs2 = 5'd7;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL load_no_match got %b exp %b", ctl, C_NORMAL);
    end
    next_cycle();
    ex_memread = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL no_memread got %b exp %b", ctl, C_NORMAL);
    end
    clear_inputs();
  endtask

  task automatic test_x0();
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    checks++;
    if (ctl !== C_NORMAL || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL x0_rule got %b exp %b", ctl, C_NORMAL);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    next_cycle();
    mem_branch_taken = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++;
      $display("FAIL branch_over_load_use got %b exp %b", ctl, C_BRANCH);
    end
    next_cycle();
    clear_inputs();
    mem_branch_taken = 1'b1;
    mem_access = 1'b1;
    #1;
    checks++;
    if (ctl !== C_MSTALL) begin
      errors++;
      $display("FAIL stall_over_branch got %b exp %b", ctl, C_MSTALL);
    end
    next_cycle();
    mem_branch_taken = 1'b0;
    dm_ack = 1'b1;
    #1;
    checks++;
    if (hz_state !== 2'd1 || ctl !== C_MADVANCE) begin
      errors++;
      $display("FAIL branch_stall_ack got st=%0d ctl=%b exp st=1 ctl=%b", hz_state, ctl, C_MADVANCE);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0) begin
      errors++;
      $display("FAIL branch_stall_exit got %0d exp 0", hz_state);
    end
  endtask

  task automatic test_zero_wait();
    next_cycle();
    mem_access = 1'b1; dm_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== C_MADVANCE) begin
      errors++;
      $display("FAIL zero_wait_ctl got %b exp %b", ctl, C_MADVANCE);
    end
    next_cycle();
    mem_access = 1'b0; dm_ack = 1'b1;
    #1;
    checks++;
    if (hz_state !== 2'd0 || ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL stray_ack got st=%0d ctl=%b exp st=0 ctl=%b", hz_state, ctl, C_NORMAL);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    next_cycle();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_MSTALL || hz_state !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL mem_wait_stall%0d got st=%0d ctl=%b exp ctl=%b", i, hz_state, ctl, C_MSTALL);
      end
      next_cycle();
    end
    dm_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== C_MADVANCE || hz_state !== 2'd1) begin
      errors++;
      $display("FAIL mem_wait_ack got st=%0d ctl=%b exp st=1 ctl=%b", hz_state, ctl, C_MADVANCE);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || mem_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_exit got st=%0d err=%b exp st=0 err=0", hz_state, mem_timeout_err);
    end
  endtask

  task automatic test_timeout();
    next_cycle();
    mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== C_MSTALL || mem_timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stall%0d got ctl=%b err=%b exp ctl=%b err=0", i, ctl, mem_timeout_err, C_MSTALL);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (ctl !== C_TIMEOUT || hz_state !== 2'd1) begin
      errors++;
      $display("FAIL timeout_exit got st=%0d ctl=%b exp st=1 ctl=%b", hz_state, ctl, C_TIMEOUT);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || mem_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after got st=%0d err=%b exp st=0 err=1", hz_state, mem_timeout_err);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (mem_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b exp 1", mem_timeout_err);
    end
  endtask

  task automatic test_reset_in_wait();
    next_cycle();
    mem_access = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (hz_state !== 2'd1) begin
      errors++;
      $display("FAIL rst_wait_enter got %0d exp 1", hz_state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (hz_state !== 2'd0 || dm_req !== 1'b0 || mem_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wait got st=%0d req=%b err=%b exp 0 0 0", hz_state, dm_req, mem_timeout_err);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_perf got stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
    end
`endif
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    next_cycle();
    checks++;
    if (hz_state !== 2'd0 || ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL rst_release got st=%0d ctl=%b exp st=0 ctl=%b", hz_state, ctl, C_NORMAL);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_zero_wait();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
